// File: rtl/isa_pkg.sv
// isa_pkg: opcode encodings, instruction field positions, decode payload
// type, branch FSM states and opcode classification helpers.
package isa_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RA_W   = 6;

  // Instruction field bit positions
  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 28;
  localparam int unsigned RD_HI = 27;
  localparam int unsigned RD_LO = 22;
  localparam int unsigned R1_HI = 21;
  localparam int unsigned R1_LO = 16;
  localparam int unsigned R2_HI = 15;
  localparam int unsigned R2_LO = 10;

  // Opcodes; any other encoding decodes as NOP
  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_NEG = 4'b0111;
  localparam logic [OP_W-1:0] OP_J   = 4'b1000;
  localparam logic [OP_W-1:0] OP_BRZ = 4'b1001;
  localparam logic [OP_W-1:0] OP_BRN = 4'b1011;
  localparam logic [OP_W-1:0] OP_LD  = 4'b1110;

  // Decoded fields kept in the holding register
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] r1;
    logic [RA_W-1:0] r2;
  } dec_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_e;

  function automatic logic is_write_rd(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG) || (op == OP_LD);
  endfunction

  function automatic logic is_flag_set(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_J) || (op == OP_BRZ) || (op == OP_BRN);
  endfunction

  function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
    return (op == OP_BRZ) || (op == OP_BRN);
  endfunction

  // ALU ops, LD (address base), ST and branches all read r1
  function automatic logic reads_r1(input logic [OP_W-1:0] op);
    return is_write_rd(op) || (op == OP_ST) || is_branch(op);
  endfunction

  function automatic logic reads_r2(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ST);
  endfunction

  // Anything that is not architecturally a NOP
  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    return is_write_rd(op) || (op == OP_ST) || is_branch(op);
  endfunction

endpackage

// File: rtl/regfile64.sv
// regfile64: register array with one write port and three asynchronous read
// ports. With IDEC_BYPASS_EN defined, a same-cycle write to a read address is
// forwarded to that read port.
module regfile64
  import isa_pkg::*;
#(
  parameter int unsigned NREG = 64,
  parameter int unsigned W    = 32
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_waddr,
  input  logic [W-1:0]    i_wdata,
  input  logic [RA_W-1:0] i_ra1,
  input  logic [RA_W-1:0] i_ra2,
  input  logic [RA_W-1:0] i_ra3,
  output logic [W-1:0]    o_rd1_c,
  output logic [W-1:0]    o_rd2_c,
  output logic [W-1:0]    o_rd3_c
);

  logic [W-1:0] r_mem [NREG];

  // Array write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef IDEC_BYPASS_EN
  assign o_rd1_c = (i_we && (i_waddr == i_ra1)) ? i_wdata : r_mem[i_ra1];
  assign o_rd2_c = (i_we && (i_waddr == i_ra2)) ? i_wdata : r_mem[i_ra2];
  assign o_rd3_c = (i_we && (i_waddr == i_ra3)) ? i_wdata : r_mem[i_ra3];
`else
  assign o_rd1_c = r_mem[i_ra1];
  assign o_rd2_c = r_mem[i_ra2];
  assign o_rd3_c = r_mem[i_ra3];
`endif

endmodule

// File: rtl/idecode_stage.sv
// idecode_stage: decode/issue stage with a one-entry holding register,
// register/flag scoreboard, fetch stall and branch redirect FSM.
// Optional macro IDEC_BYPASS_EN: same-cycle writeback forwarding.
module idecode_stage
  import isa_pkg::*;
#(
  parameter int unsigned NREG = 64,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst,
  input  logic [INST_W-1:0] pc,
  output logic              stall,
  output logic              brz,
  output logic              brn,
  output logic              j,
  output logic [W-1:0]      rd1,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [RA_W-1:0]   ex_rd,
  output logic [W-1:0]      ex_a,
  output logic [W-1:0]      ex_b,
  output logic [INST_W-1:0] ex_pc,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [W-1:0]      wb_data,
  input  logic              flag_we,
  input  logic              flag_z,
  input  logic              flag_n
);

  dec_t              w_in_dec;
  logic              w_unused_low;
  logic              r_valid;
  dec_t              r_dec;
  logic [INST_W-1:0] r_pc;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_eff;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_flags_busy;
  logic              r_z;
  logic              r_n;
  logic              w_hazard;
  logic              w_issue;
  logic              w_ex_issue;
  logic              w_accept;
  logic [W-1:0]      w_r1_data;
  logic [W-1:0]      w_r2_data;
  logic [W-1:0]      w_br_data;
  br_state_e         r_state;
  br_state_e         w_state_nxt;
  logic              w_brz_nxt;
  logic              w_brn_nxt;
  logic              w_j_nxt;
  logic [W-1:0]      w_rd1_nxt;
  logic              r_brz;
  logic              r_brn;
  logic              r_j;
  logic [W-1:0]      r_rd1;
  logic              r_ex_valid;
  logic [OP_W-1:0]   r_ex_op;
  logic [RA_W-1:0]   r_ex_rd;
  logic [W-1:0]      r_ex_a;
  logic [W-1:0]      r_ex_b;
  logic [INST_W-1:0] r_ex_pc;

  assign w_in_dec     = {inst[OP_HI:OP_LO], inst[RD_HI:RD_LO],
                         inst[R1_HI:R1_LO], inst[R2_HI:R2_LO]};
  assign w_unused_low = ^inst[R2_LO-1:0];

  regfile64 #(.NREG(NREG), .W(W)) u_rf (
    .clk     (clk),
    .i_we    (wb_en),
    .i_waddr (wb_addr),
    .i_wdata (wb_data),
    .i_ra1   (r_dec.r1),
    .i_ra2   (r_dec.r2),
    .i_ra3   (r_dec.r1),
    .o_rd1_c (w_r1_data),
    .o_rd2_c (w_r2_data),
    .o_rd3_c (w_br_data)
  );

  // Busy view used for hazard detection; a forwarded writeback hides its bit
  always_comb begin
    w_busy_eff = r_busy;
`ifdef IDEC_BYPASS_EN
    if (wb_en) w_busy_eff[wb_addr] = 1'b0;
`endif
  end

  // Hazards on the held instruction; a branch also waits out a live redirect
  assign w_hazard = (reads_r1(r_dec.op) && w_busy_eff[r_dec.r1])
                 || (reads_r2(r_dec.op) && w_busy_eff[r_dec.r2])
                 || (is_cond_branch(r_dec.op) && r_flags_busy)
                 || (is_branch(r_dec.op) && (r_state == ST_REDIRECT));

  assign w_issue    = r_valid && !w_hazard;
  assign w_ex_issue = w_issue && !is_branch(r_dec.op);
  assign stall      = (r_valid && w_hazard)
                   || ((r_state == ST_REDIRECT) && (inst != '0));
  assign w_accept   = !stall;

  // Holding register: load on accept, drain on issue, keep while blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_pc    <= '0;
    end else if (w_accept) begin
      r_valid <= is_known_op(w_in_dec.op);
      r_dec   <= w_in_dec;
      r_pc    <= pc;
    end else if (w_issue) begin
      r_valid <= 1'b0;
    end
  end

  // Scoreboard next state: writeback clears, issue sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
    if (w_issue && is_write_rd(r_dec.op)) w_busy_nxt[r_dec.rd] = 1'b1;
  end

  // Scoreboard and flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_flags_busy <= 1'b0;
      r_z          <= 1'b0;
      r_n          <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flag_we) begin
        r_z <= flag_z;
        r_n <= flag_n;
      end
      if (w_issue && is_flag_set(r_dec.op)) r_flags_busy <= 1'b1;
      else if (flag_we)                     r_flags_busy <= 1'b0;
    end
  end

  // Branch FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Branch FSM next state and redirect pulse values
  always_comb begin
    w_state_nxt = r_state;
    w_brz_nxt   = 1'b0;
    w_brn_nxt   = 1'b0;
    w_j_nxt     = 1'b0;
    w_rd1_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue && is_branch(r_dec.op)) begin
          w_state_nxt = ST_REDIRECT;
          w_j_nxt     = (r_dec.op == OP_J);
          w_brz_nxt   = (r_dec.op == OP_BRZ) && r_z;
          w_brn_nxt   = (r_dec.op == OP_BRN) && r_n;
          if ((r_dec.op == OP_J) || ((r_dec.op == OP_BRZ) && r_z)
              || ((r_dec.op == OP_BRN) && r_n)) begin
            w_rd1_nxt = w_br_data;
          end
        end
      end
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered redirect and issue outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brz      <= 1'b0;
      r_brn      <= 1'b0;
      r_j        <= 1'b0;
      r_rd1      <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_pc    <= '0;
    end else begin
      r_brz      <= w_brz_nxt;
      r_brn      <= w_brn_nxt;
      r_j        <= w_j_nxt;
      r_rd1      <= w_rd1_nxt;
      r_ex_valid <= w_ex_issue;
      r_ex_op    <= w_ex_issue ? r_dec.op  : '0;
      r_ex_rd    <= w_ex_issue ? r_dec.rd  : '0;
      r_ex_a     <= w_ex_issue ? w_r1_data : '0;
      r_ex_b     <= w_ex_issue ? w_r2_data : '0;
      r_ex_pc    <= w_ex_issue ? r_pc      : '0;
    end
  end

  assign brz      = r_brz;
  assign brn      = r_brn;
  assign j        = r_j;
  assign rd1      = r_rd1;
  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_rd    = r_ex_rd;
  assign ex_a     = r_ex_a;
  assign ex_b     = r_ex_b;
  assign ex_pc    = r_ex_pc;

endmodule
